spi_responder: RTL



---
 rtl/spi_responder_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/spi_responder_pkg.sv
// Shared types and command-byte field positions for the SPI responder.
// Mirrors the MAX3421E command layout: addr[7:3], dir[1], ackstat[0].
package spi_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA_WR,
        DATA_RD
    } spi_state_t;

    localparam int ADDR_MSB  = 7;
    localparam int ADDR_LSB  = 3;
    localparam int DIR_BIT   = 1;
    localparam int ACK_BIT   = 0;
    localparam int REG_COUNT = 32;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with single-cycle rise/fall pulses.
// Chain resets low so an idle-low SCLK produces no spurious edge.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    assign level = sync_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= level;
        end
    end

    assign rise_o = level & ~prev_q;
    assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_responder.sv
// Mode-0 SPI slave speaking a MAX3421E-style command protocol
// over a 32x8 register file shared with the fabric.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter logic [4:0] STATUS_ADDR = 5'd25,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_ss_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [4:0] fab_addr,
    input  logic       fab_we,
    input  logic [7:0] fab_wdata,
    output logic [7:0] fab_rdata,
    output logic       wr_strobe,
    output logic [4:0] wr_addr,
    output logic       busy
);

    spi_state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   ss_prev_q;

    logic       ss_s, ss_fall, mosi_s;
    logic       sclk_rise, sclk_fall;
    logic       active, byte_done, spi_wr;
    logic [7:0] rx_byte;

    logic [2:0] cnt_q;
    logic [6:0] rx_q;
    logic [7:0] tx_q;
    logic [7:0] pend_q;
    logic       load_q;
    logic [4:0] addr_q;
    logic [7:0] fab_rdata_q;
    logic       wr_strobe_q;
    logic [4:0] wr_addr_q;
    logic [7:0] regs_q [REG_COUNT];

    spi_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sclk (
        .clk    (clk),
        .reset  (reset),
        .d_i    (spi_sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // SS_n resets to "low" so a reset mid-frame needs a fresh high->low
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            ss_prev_q   <= ss_s;
        end
    end

    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_fall   = ss_prev_q & ~ss_s;
    assign active    = (state_q != IDLE) && !ss_s;
    assign rx_byte   = {rx_q, mosi_s};
    assign byte_done = sclk_rise && (state_q != IDLE) && (cnt_q == 3'd7);
    assign spi_wr    = byte_done && (state_q == DATA_WR);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ss_fall) state_d = CMD;
            end
            CMD: begin
                if (ss_s)
                    state_d = IDLE;
                else if (byte_done)
                    state_d = rx_byte[DIR_BIT] ? DATA_WR : DATA_RD;
            end
            DATA_WR, DATA_RD: begin
                if (ss_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        spi_miso_oe = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            IDLE: ;
            CMD, DATA_WR, DATA_RD: begin
                spi_miso_oe = 1'b1;
                busy        = 1'b1;
            end
            default: ;
        endcase
    end

    // New bytes wait in pend_q and enter tx_q on the next fall
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            pend_q      <= '0;
            load_q      <= 1'b0;
            addr_q      <= '0;
            fab_rdata_q <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
        end else begin
            wr_strobe_q <= 1'b0;
            fab_rdata_q <= regs_q[fab_addr];
            if (fab_we) regs_q[fab_addr] <= fab_wdata;
            if (spi_wr) begin
                regs_q[addr_q] <= rx_byte;
                wr_strobe_q    <= 1'b1;
                wr_addr_q      <= addr_q;
            end

            if (state_q == IDLE && ss_fall) begin
                tx_q   <= regs_q[STATUS_ADDR];
                cnt_q  <= '0;
                load_q <= 1'b0;
            end else if (!active) begin
                cnt_q  <= '0;
                load_q <= 1'b0;
            end else if (sclk_rise) begin
                cnt_q <= cnt_q + 3'd1;
                rx_q  <= rx_byte[6:0];
                if (byte_done) begin
                    load_q <= 1'b1;
                    unique case (state_q)
                        CMD: begin
                            addr_q <= rx_byte[ADDR_MSB:ADDR_LSB];
                            pend_q <= rx_byte[DIR_BIT] ? 8'h00
                                    : regs_q[rx_byte[ADDR_MSB:ADDR_LSB]];
                        end
                        DATA_RD: pend_q <= regs_q[addr_q];
                        default: pend_q <= 8'h00;
                    endcase
                end
            end else if (sclk_fall) begin
                if (load_q) begin
                    tx_q   <= pend_q;
                    load_q <= 1'b0;
                end else begin
                    tx_q <= {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso  = spi_miso_oe & tx_q[7];
    assign fab_rdata = fab_rdata_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule
